// File: rtl/reg_cmd_pkg.sv
// Shared definitions for the register-file command controller.
// Provides the FSM state encoding, default opcodes and default widths.
// Build option: REG_CMD_RD_TIMEOUT_EN (read-wait watchdog) is consumed in reg_cmd_ctrl.
package reg_cmd_pkg;

    localparam int         DEF_WIDTH         = 8;
    localparam int         DEF_ADDRESS_WIDTH = 4;
    localparam logic [7:0] DEF_WR_CMD        = 8'hAA;
    localparam logic [7:0] DEF_RD_CMD        = 8'hBB;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        WR_EXEC = 3'd3,
        RD_ADDR = 3'd4,
        RD_EXEC = 3'd5,
        RD_WAIT = 3'd6,
        TX_SEND = 3'd7
    } state_t;

endpackage

// File: rtl/reg_cmd_watchdog.sv
// Cycle watchdog for the read-data wait: cleared by clear, counts while enable.
// Latency: expire is combinational from the count, high on the LIMIT-th enabled cycle.
// Backpressure: none; stops counting once expired until cleared.
// Ports: clk, rst (async, active-high), clear, enable, expire.
module reg_cmd_watchdog #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + CW'(1);
        end
    end

    // count holds the number of enabled cycles already completed, so the
    // LIMIT-th enabled cycle sees LIMIT-1.
    assign expire = enable && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/reg_cmd_ctrl.sv
// Byte-stream command decoder driving an 8x16 register file; read data is sent to the UART TX path.
// Latency: WrEn/RdEn one cycle after the last frame byte is sampled; TX_D_VLD two cycles after RdData_Valid.
// Backpressure: TX_Busy holds TX_D_VLD indefinitely; bytes arriving mid-access are dropped with Cmd_Err.
// Ports: CLK, RST (async active-high); RX_P_DATA/RX_D_VLD in; WrEn/RdEn/Address/WrData to the register
// file; RdData/RdData_Valid from it; TX_P_DATA/TX_D_VLD/TX_Busy to the transmitter; Cmd_Err pulse.
// Build option: define REG_CMD_RD_TIMEOUT_EN to abort a read after RD_TIMEOUT cycles without data.
module reg_cmd_ctrl
    import reg_cmd_pkg::*;
#(
    parameter int               WIDTH         = DEF_WIDTH,
    parameter int               ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter logic [WIDTH-1:0] WR_CMD        = WIDTH'(DEF_WR_CMD),
    parameter logic [WIDTH-1:0] RD_CMD        = WIDTH'(DEF_RD_CMD),
    parameter int               RD_TIMEOUT    = 15
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [WIDTH-1:0]         RX_P_DATA,
    input  logic                     RX_D_VLD,
    output logic                     WrEn,
    output logic                     RdEn,
    output logic [ADDRESS_WIDTH-1:0] Address,
    output logic [WIDTH-1:0]         WrData,
    input  logic [WIDTH-1:0]         RdData,
    input  logic                     RdData_Valid,
    output logic [WIDTH-1:0]         TX_P_DATA,
    output logic                     TX_D_VLD,
    input  logic                     TX_Busy,
    output logic                     Cmd_Err
);

    state_t                   state, state_nxt;
    logic [ADDRESS_WIDTH-1:0] addr_nxt;
    logic [WIDTH-1:0]         wdata_nxt;
    logic [WIDTH-1:0]         txd_nxt;
    logic                     wr_en_nxt;
    logic                     rd_en_nxt;
    logic                     tx_vld_nxt;
    logic                     err_nxt;
    logic                     rd_expire;

`ifdef REG_CMD_RD_TIMEOUT_EN
    // Cleared during the RdEn cycle so the count starts at zero on entry to RD_WAIT.
    reg_cmd_watchdog #(
        .LIMIT (RD_TIMEOUT)
    ) u_watchdog (
        .clk    (CLK),
        .rst    (RST),
        .clear  (state == RD_EXEC),
        .enable (state == RD_WAIT),
        .expire (rd_expire)
    );
`else
    // No watchdog in this build: the term is constant-false and RD_WAIT waits forever.
    assign rd_expire = (RD_TIMEOUT < 0);
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        addr_nxt   = Address;
        wdata_nxt  = WrData;
        txd_nxt    = TX_P_DATA;
        wr_en_nxt  = 1'b0;
        rd_en_nxt  = 1'b0;
        tx_vld_nxt = 1'b0;
        err_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == WR_CMD) begin
                        state_nxt = WR_ADDR;
                    end else if (RX_P_DATA == RD_CMD) begin
                        state_nxt = RD_ADDR;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            WR_ADDR, RD_ADDR: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA[WIDTH-1:ADDRESS_WIDTH] != '0) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        addr_nxt = RX_P_DATA[ADDRESS_WIDTH-1:0];
                        if (state == WR_ADDR) begin
                            state_nxt = WR_DATA;
                        end else begin
                            state_nxt = RD_EXEC;
                            rd_en_nxt = 1'b1;
                        end
                    end
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    wdata_nxt = RX_P_DATA;
                    state_nxt = WR_EXEC;
                    wr_en_nxt = 1'b1;
                end
            end
            WR_EXEC: begin
                err_nxt   = RX_D_VLD;
                state_nxt = IDLE;
            end
            RD_EXEC: begin
                err_nxt   = RX_D_VLD;
                state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                err_nxt = RX_D_VLD;
                // Data arriving on the expiry cycle takes priority over the abort.
                if (RdData_Valid) begin
                    txd_nxt   = RdData;
                    state_nxt = TX_SEND;
                end else if (rd_expire) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            TX_SEND: begin
                err_nxt = RX_D_VLD;
                if (!TX_Busy) begin
                    tx_vld_nxt = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Every output is a flop loaded from the next-state logic above.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            WrEn      <= 1'b0;
            RdEn      <= 1'b0;
            Address   <= '0;
            WrData    <= '0;
            TX_P_DATA <= '0;
            TX_D_VLD  <= 1'b0;
            Cmd_Err   <= 1'b0;
        end else begin
            WrEn      <= wr_en_nxt;
            RdEn      <= rd_en_nxt;
            Address   <= addr_nxt;
            WrData    <= wdata_nxt;
            TX_P_DATA <= txd_nxt;
            TX_D_VLD  <= tx_vld_nxt;
            Cmd_Err   <= err_nxt;
        end
    end

endmodule
